// File: rtl/axi_lite_rd_master.sv
// Single-outstanding AXI-lite read master that turns IFU fetch requests into AR/R transactions.
// Define AXI_RD_TIMEOUT_EN to add a response watchdog and a DRAIN state for late read data.
module axi_lite_rd_master #(
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [2:0]  AR_PROT        = 3'b100,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BUS_WIDTH-1:0]  req_addr,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [BUS_WIDTH-1:0]  ar_addr,
    output logic [2:0]            ar_prot,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [1:0]            rd_resp
);

    localparam int unsigned ALIGN_BITS = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
`ifdef AXI_RD_TIMEOUT_EN
        , StDrain
`endif
    } state_e;

    state_e                state_q, state_d;
    logic                  ar_valid_q, ar_valid_d;
    logic [BUS_WIDTH-1:0]  ar_addr_q, ar_addr_d;
    logic                  rd_ready_q, rd_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic                  discard_q, discard_d;
    logic                  misaligned;
    logic                  drop_now;

`ifdef AXI_RD_TIMEOUT_EN
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
`endif

    // Flags a watchdog limit that does not fit its counter; keeps both knobs referenced.
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES >= (64'd1 << CNT_WIDTH));

    assign req_ready  = (state_q == StIdle) && !flush;
    assign misaligned = |req_addr[ALIGN_BITS-1:0];
    // A flush arriving together with the data beat still cancels the response.
    assign drop_now   = discard_q || flush;

    always_comb begin
        state_d      = state_q;
        ar_valid_d   = ar_valid_q;
        ar_addr_d    = ar_addr_q;
        rd_ready_d   = rd_ready_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        discard_d    = discard_q;
`ifdef AXI_RD_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                discard_d = 1'b0;
                if (req_valid && req_ready) begin
                    if (misaligned) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                    end else begin
                        ar_addr_d  = req_addr;
                        ar_valid_d = 1'b1;
                        state_d    = StAddr;
                    end
                end
            end
            StAddr: begin
                if (flush) discard_d = 1'b1;
                if (ar_ready) begin
                    ar_valid_d = 1'b0;
                    rd_ready_d = 1'b1;
                    state_d    = StData;
`ifdef AXI_RD_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            StData: begin
                if (flush) discard_d = 1'b1;
                if (rd_valid) begin
                    rd_ready_d = 1'b0;
                    state_d    = StIdle;
                    discard_d  = 1'b0;
                    if (!drop_now) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = rd_data;
                        resp_err_d   = (rd_resp != 2'b00);
                    end
                end
`ifdef AXI_RD_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_d == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                        state_d = StDrain;
                        if (!drop_now) begin
                            resp_valid_d = 1'b1;
                            resp_err_d   = 1'b1;
                            resp_data_d  = '0;
                        end
                    end
                end
`endif
            end
`ifdef AXI_RD_TIMEOUT_EN
            StDrain: begin
                if (rd_valid) begin
                    rd_ready_d = 1'b0;
                    state_d    = StIdle;
                    discard_d  = 1'b0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            ar_valid_q   <= 1'b0;
            ar_addr_q    <= '0;
            rd_ready_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            discard_q    <= 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ar_valid_q   <= ar_valid_d;
            ar_addr_q    <= ar_addr_d;
            rd_ready_q   <= rd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            discard_q    <= discard_d;
`ifdef AXI_RD_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign ar_valid   = ar_valid_q;
    assign ar_addr    = ar_addr_q;
    assign ar_prot    = AR_PROT;
    assign rd_ready   = rd_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_axi_lite_rd_master.sv
// Self-checking bench for axi_lite_rd_master: directed and random fetches against a timeline model.
module tb_axi_lite_rd_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_data = '0;
    logic        exp_err  = 1'b0;

    always #5 clk = ~clk;

    axi_lite_rd_master #(
        .BUS_WIDTH     (32),
        .DATA_WIDTH    (32),
        .AR_PROT       (3'b100),
        .TIMEOUT_CYCLES(8),
        .CNT_WIDTH     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_addr   (ar_addr),
        .ar_prot   (ar_prot),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_resp   (rd_resp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One fetch, cycle by cycle. Cycle 0 is the accept cycle; the model derives every
    // expected output from the handshake delays: aw = cycles ar_ready is held low,
    // rw = DATA cycles before rd_valid, fl = cycle carrying a one-cycle flush (-1: none).
    task automatic run_txn(input logic [31:0] addr, input int aw, input int rw,
                           input logic [31:0] data, input logic [1:0] resp, input int fl);
        bit aligned = (addr[1:0] == 2'b00);
        int last    = aligned ? 3 + aw + rw : 1;
        bit dropped = aligned && (fl >= 1) && (fl <= 2 + aw + rw);
        for (int c = 0; c <= last; c++) begin
            bit in_ar = aligned && (c >= 1) && (c <= 1 + aw);
            bit in_rd = aligned && (c >= 2 + aw) && (c <= 2 + aw + rw);
            bit idle  = !aligned || (c == 0) || (c == last);
            req_valid = (c == 0) ? 1'b1 : ((c == last) ? 1'b0 : 1'($urandom_range(0, 1)));
            req_addr  = (c == 0) ? addr : $urandom;
            flush     = (c == fl);
            ar_ready  = in_ar ? (c == 1 + aw) : 1'($urandom_range(0, 1));
            rd_valid  = in_rd ? (c == 2 + aw + rw) : (aligned ? 1'b0 : 1'($urandom_range(0, 1)));
            rd_data   = (c == 2 + aw + rw) ? data : $urandom;
            rd_resp   = (c == 2 + aw + rw) ? resp : 2'($urandom_range(0, 3));
            #1;
            check("req_ready", req_ready, idle && !flush);
            check("ar_valid", ar_valid, in_ar);
            if (in_ar) check("ar_addr", ar_addr, addr);
            check("rd_ready", rd_ready, in_rd);
            if (c == last && !dropped) begin
                exp_data = aligned ? data : 32'h0;
                exp_err  = aligned ? (resp != 2'b00) : 1'b1;
            end
            check("resp_valid", resp_valid, (c == last) && !dropped);
            check("resp_data", resp_data, exp_data);
            check("resp_err", resp_err, exp_err);
            step();
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        ar_ready  = 1'b0;
        rd_valid  = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        ar_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        rd_resp   = '0;
        step();
        check("rst_ar_valid", ar_valid, 1'b0);
        check("rst_ar_addr", ar_addr, 32'h0);
        check("rst_rd_ready", rd_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_err", resp_err, 1'b0);
        check("ar_prot", ar_prot, 3'b100);
        reset = 1'b1;
        step();

        run_txn(32'h1C00_0000, 0, 0, 32'hDEAD_BEEF, 2'b00, -1);
        run_txn(32'h1C00_0000, 4, 0, 32'h0BAD_F00D, 2'b00, -1);
        run_txn(32'h1C00_0000, 2, 1, 32'h1111_1111, 2'b00, 1);
        run_txn(32'h1C00_0004, 0, 0, 32'h2222_2222, 2'b00, -1);
        run_txn(32'h1C00_0000, 0, 3, 32'h3333_3333, 2'b00, 3);
        run_txn(32'h1C00_0004, 0, 0, 32'h4444_4444, 2'b00, -1);
        run_txn(32'h1C00_0000, 0, 1, 32'h5555_5555, 2'b00, 3);

        // Flush while idle only blocks acceptance.
        req_valid = 1'b1;
        req_addr  = 32'h1C00_0008;
        flush     = 1'b1;
        #1;
        check("idle_flush_ready", req_ready, 1'b0);
        step();
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        check("idle_flush_ar_valid", ar_valid, 1'b0);
        check("idle_flush_resp", resp_valid, 1'b0);
        step();

        run_txn(32'h1C00_0002, 0, 0, 32'h0, 2'b00, -1);
        run_txn(32'h1C00_0000, 1, 2, 32'h1234_5678, 2'b10, -1);

        // Reset in the middle of an address phase.
        req_valid = 1'b1;
        req_addr  = 32'h1C00_0010;
        step();
        req_valid = 1'b0;
        check("pre_reset_ar_valid", ar_valid, 1'b1);
        reset = 1'b0;
        #1;
        exp_data = '0;
        exp_err  = 1'b0;
        check("mid_rst_ar_valid", ar_valid, 1'b0);
        check("mid_rst_ar_addr", ar_addr, 32'h0);
        check("mid_rst_rd_ready", rd_ready, 1'b0);
        check("mid_rst_resp_data", resp_data, exp_data);
        check("mid_rst_resp_err", resp_err, exp_err);
        check("mid_rst_req_ready", req_ready, 1'b1);
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int          aw;
            int          rw;
            int          fl;
            a  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            aw = $urandom_range(0, 4);
            rw = $urandom_range(0, 5);
            fl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 + aw + rw) : -1;
            run_txn(a, aw, rw, $urandom, 2'($urandom_range(0, 3)), fl);
        end

`ifdef AXI_RD_TIMEOUT_EN
        // rd_valid withheld 20 DATA cycles against an 8-cycle watchdog.
        for (int c = 0; c <= 23; c++) begin
            req_valid = (c == 0);
            req_addr  = 32'h1C00_0008;
            ar_ready  = (c == 1);
            rd_valid  = (c == 22);
            rd_data   = 32'hCAFE_F00D;
            rd_resp   = 2'b00;
            #1;
            if (c == 10) begin
                exp_data = '0;
                exp_err  = 1'b1;
            end
            check("to_rd_ready", rd_ready, (c >= 2) && (c <= 22));
            check("to_resp_valid", resp_valid, c == 10);
            check("to_resp_data", resp_data, exp_data);
            check("to_resp_err", resp_err, exp_err);
            check("to_req_ready", req_ready, (c == 0) || (c == 23));
            step();
        end
        rd_valid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_rd_master.md
Name: axi_lite_rd_master

Overview:
- Single-outstanding AXI-lite read master controller that sequences fetch requests from the IFU onto the AXI-lite read address and read data channels.
- Its AXI side connects to the IFU-side inst_ar_* / inst_rd_* inputs of the core's IFU/LSU AXI-lite arbiter.
- Handles misalignment checks and pipeline flush, where an in-flight response is discarded.
- Optionally runs a response watchdog.

Parameters:
- BUS_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; alignment is DATA_WIDTH/8 bytes.
- AR_PROT, 3'b100, constant driven on ar_prot (instruction access).
- TIMEOUT_CYCLES, 255, watchdog limit in cycles, used only with the optional feature.
- CNT_WIDTH, 8, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request.
- req_ready  out  1  controller can accept a request.
- req_addr  in  BUS_WIDTH  fetch address.
- flush  in  1  pipeline flush; cancels the pending request's response.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_data  out  DATA_WIDTH  response data.
- resp_err  out  1  error flag, qualified by resp_valid.
- ar_valid  out  1  AXI read address valid.
- ar_ready  in  1  AXI read address ready.
- ar_addr  out  BUS_WIDTH  AXI read address.
- ar_prot  out  3  tied to AR_PROT.
- rd_valid  in  1  AXI read data valid.
- rd_ready  out  1  AXI read data ready.
- rd_data  in  DATA_WIDTH  AXI read data.
- rd_resp  in  2  AXI read response; nonzero is an error.

Behaviour:
- Reset (reset=0, async): state=IDLE.
  - All registered outputs 0: ar_valid, ar_addr, rd_ready, resp_valid, resp_data, resp_err.
  - Discard flag and watchdog counter cleared.
- req_ready = (state==IDLE) & ~flush, combinational. A request is accepted when req_valid & req_ready.
- States: IDLE, ADDR, DATA, plus DRAIN when the optional feature is compiled in.
- IDLE:
  - On an aligned accept: latch req_addr into ar_addr, set ar_valid=1, go to ADDR.
  - On a misaligned accept (req_addr[log2(DATA_WIDTH/8)-1:0] != 0): no bus transaction; next cycle resp_valid=1, resp_err=1, resp_data=0; stay IDLE.
- ADDR:
  - ar_valid and ar_addr are held stable until ar_ready (AXI rule); a flush does not drop ar_valid.
  - On ar_ready: ar_valid=0, rd_ready=1, go to DATA.
- DATA:
  - On rd_valid: rd_ready=0, go to IDLE.
  - Unless discarding: next cycle resp_valid=1, resp_data=rd_data, resp_err=(rd_resp!=0).
- Flush:
  - flush=1 in ADDR or DATA sets the discard flag.
  - A discarded transaction completes on AXI normally but produces no resp_valid; the discard flag clears on return to IDLE.
  - flush in IDLE blocks acceptance only.
  - flush in the same cycle as rd_valid also discards.
- resp_valid pulses exactly one cycle; otherwise 0. resp_data and resp_err hold their last values.
- Minimum latency: accept at T -> ar_valid at T+1 -> (ar_ready at T+1) rd_ready at T+2 -> (rd_valid at T+2) resp_valid at T+3.
- At most one transaction is outstanding; no new accept occurs until back in IDLE.
- Reset asserted mid-transaction aborts immediately to IDLE with outputs at reset values.

Optional Feature:
- Macro: AXI_RD_TIMEOUT_EN.
- With it defined:
  - The watchdog counter clears on entry to DATA and increments each DATA cycle without rd_valid.
  - When the counter reaches TIMEOUT_CYCLES: next cycle resp_valid=1, resp_err=1, resp_data=0 (suppressed if discarding); enter DRAIN with rd_ready held at 1.
  - In DRAIN, the late rd_valid is consumed silently, then the controller returns to IDLE.
  - ADDR has no timeout.
- Without it: no counter and no DRAIN state; DATA waits indefinitely.

Test Plan:
- Aligned fetch: req_addr=0x1C00_0000, ar_ready and rd_valid asserted immediately, rd_data=0xDEADBEEF, rd_resp=0 -> resp_valid at T+3, resp_data=0xDEADBEEF, resp_err=0.
- Backpressure: ar_ready held low 4 cycles -> ar_valid/ar_addr stable for all 4 cycles; resp arrives 4 cycles later than the minimum.
- Flush in ADDR and in DATA: flush=1 for one cycle during each state -> AXI handshakes complete, no resp_valid; the next request at 0x1C00_0004 returns its data normally.
- Misaligned: req_addr=0x1C00_0002 -> ar_valid never asserts; resp_valid=1 with resp_err=1 and resp_data=0 one cycle after accept.
- Slave error: rd_resp=2'b10, rd_data=0x12345678 -> resp_err=1 and resp_data=0x12345678.
- AXI_RD_TIMEOUT_EN with TIMEOUT_CYCLES=8: rd_valid withheld 20 cycles -> resp_err=1 pulse after 8 DATA cycles; the late rd_valid is consumed with no extra resp_valid; then IDLE.
